// File: rtl/hazard_scoreboard.sv
// ID-stage register/flag scoreboard: counts in-flight writes per register and in-flight
// status-register updates, and raises hazard to stall ID. Optional stats: HAZARD_SCOREBOARD_STATS_EN.
module hazard_scoreboard #(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4,
    parameter int CNT_W    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rn,
    input  logic [ADDR_W-1:0] id_src2,
    input  logic              id_two_src,
    input  logic              id_wb_en,
    input  logic [ADDR_W-1:0] id_dest,
    input  logic              id_s,
    input  logic              id_cond_use,
    input  logic              flush,
    input  logic              wb_wb_en,
    input  logic [ADDR_W-1:0] wb_dest,
    input  logic              sr_commit,
`ifdef HAZARD_SCOREBOARD_STATS_EN
    output logic [31:0]       stall_cycles,
    output logic [31:0]       issued_cnt,
`endif
    output logic              hazard,
    output logic              issue,
    output logic              sb_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0]    cnt_q [NUM_REGS];
    logic [CNT_W-1:0]    cnt_d [NUM_REGS];
    logic [NUM_REGS-1:0] reg_err;
    logic [CNT_W-1:0]    sflag_cnt_q, sflag_cnt_d;
    logic                sflag_err;
    logic                sb_err_q, sb_err_d;
    logic                hazard_raw;

    always_comb begin
        hazard_raw = (cnt_q[id_rn] != '0)
                   | (id_two_src  & (cnt_q[id_src2] != '0))
                   | (id_wb_en    & (cnt_q[id_dest] == CNT_MAX))
                   | (id_cond_use & (sflag_cnt_q != '0))
                   | (id_s        & (sflag_cnt_q == CNT_MAX));
        // Gated by rst so the outputs are quiet while counters are being cleared.
        hazard = ~rst & id_valid & hazard_raw;
        issue  = ~rst & id_valid & ~hazard_raw & ~flush;
    end

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic reg_inc, reg_dec;
            assign reg_inc = issue & id_wb_en & (id_dest == ADDR_W'(gi));
            assign reg_dec = wb_wb_en & (wb_dest == ADDR_W'(gi));
            // Same-cycle issue and retire cancel; a retire at zero holds at zero and flags an error.
            assign cnt_d[gi] = (reg_inc & ~reg_dec) ? cnt_q[gi] + CNT_W'(1) :
                               (reg_dec & ~reg_inc & (cnt_q[gi] != '0)) ? cnt_q[gi] - CNT_W'(1) :
                               cnt_q[gi];
            assign reg_err[gi] = reg_dec & ~reg_inc & (cnt_q[gi] == '0);
        end
    endgenerate

    always_comb begin
        logic s_inc;
        s_inc       = issue & id_s;
        sflag_cnt_d = sflag_cnt_q;
        sflag_err   = 1'b0;
        if (s_inc & ~sr_commit) begin
            sflag_cnt_d = sflag_cnt_q + CNT_W'(1);
        end else if (sr_commit & ~s_inc) begin
            if (sflag_cnt_q == '0) begin
                sflag_err = 1'b1;
            end else begin
                sflag_cnt_d = sflag_cnt_q - CNT_W'(1);
            end
        end
        sb_err_d = sb_err_q | (|reg_err) | sflag_err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= '0;
            end
            sflag_cnt_q <= '0;
            sb_err_q    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            sflag_cnt_q <= sflag_cnt_d;
            sb_err_q    <= sb_err_d;
        end
    end

    assign sb_err = sb_err_q;

`ifdef HAZARD_SCOREBOARD_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] issued_cnt_q, issued_cnt_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q + {31'd0, hazard & ~flush};
        issued_cnt_d   = issued_cnt_q + {31'd0, issue};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            issued_cnt_q   <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            issued_cnt_q   <= issued_cnt_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign issued_cnt   = issued_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus randomized
// traffic compared against a per-register pending-count model.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid, id_two_src, id_wb_en, id_s, id_cond_use, flush;
    logic       wb_wb_en, sr_commit;
    logic [3:0] id_rn, id_src2, id_dest, wb_dest;
    logic       hazard, issue, sb_err;
`ifdef HAZARD_SCOREBOARD_STATS_EN
    logic [31:0] stall_cycles, issued_cnt;
`endif

    int checks = 0;
    int fails  = 0;

    // Reference model: number of outstanding writers per register / flag updates.
    int m_cnt [16];
    int m_sflag = 0;
    bit m_err   = 1'b0;
    int m_stall = 0;
    int m_issued = 0;

    hazard_scoreboard dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rn(id_rn), .id_src2(id_src2), .id_two_src(id_two_src),
        .id_wb_en(id_wb_en), .id_dest(id_dest), .id_s(id_s), .id_cond_use(id_cond_use),
        .flush(flush), .wb_wb_en(wb_wb_en), .wb_dest(wb_dest), .sr_commit(sr_commit),
`ifdef HAZARD_SCOREBOARD_STATS_EN
        .stall_cycles(stall_cycles), .issued_cnt(issued_cnt),
`endif
        .hazard(hazard), .issue(issue), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    function automatic bit exp_hazard();
        if (rst || !id_valid) return 1'b0;
        return (m_cnt[id_rn] > 0)
            || (id_two_src  && m_cnt[id_src2] > 0)
            || (id_wb_en    && m_cnt[id_dest] >= 3)
            || (id_cond_use && m_sflag > 0)
            || (id_s        && m_sflag >= 3);
    endfunction

    function automatic bit exp_issue();
        return !rst && id_valid && !exp_hazard() && !flush;
    endfunction

    always @(posedge clk) begin
        bit iss, h;
        int delta;
        h   = exp_hazard();
        iss = exp_issue();
        if (rst) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_sflag = 0; m_err = 1'b0; m_stall = 0; m_issued = 0;
        end else begin
            if (h && !flush) m_stall++;
            if (iss) m_issued++;
            for (int r = 0; r < 16; r++) begin
                delta = ((iss && id_wb_en && id_dest == r) ? 1 : 0)
                      - ((wb_wb_en && wb_dest == r) ? 1 : 0);
                if (delta < 0 && m_cnt[r] == 0) m_err = 1'b1;
                else m_cnt[r] += delta;
            end
            delta = ((iss && id_s) ? 1 : 0) - (sr_commit ? 1 : 0);
            if (delta < 0 && m_sflag == 0) m_err = 1'b1;
            else m_sflag += delta;
        end
    end

    task automatic idle();
        id_valid = 0; id_rn = 0; id_src2 = 0; id_two_src = 0; id_wb_en = 0; id_dest = 0;
        id_s = 0; id_cond_use = 0; flush = 0; wb_wb_en = 0; wb_dest = 0; sr_commit = 0;
    endtask

    task automatic step();
        @(negedge clk);
        idle();
    endtask

    task automatic test_reset();
        idle();
        id_valid = 1; id_rn = 3;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            checks++;
            if (hazard !== 1'b0 || issue !== 1'b0 || sb_err !== 1'b0) begin
                fails++;
                $display("FAIL reset_hold: hazard=%b issue=%b sb_err=%b required 0 0 0", hazard, issue, sb_err);
            end
        end
        @(negedge clk);
        rst = 0; #1;
        checks++;
        if (issue !== 1'b1 || hazard !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: issue=%b hazard=%b required 1 0", issue, hazard);
        end
        $display("test_reset done");
    endtask

    task automatic test_raw();
        step(); id_valid = 1; id_wb_en = 1; id_dest = 1; #1;
        checks++;
        if (issue !== 1'b1) begin fails++; $display("FAIL raw_first_issue: issue=%b required 1", issue); end
        for (int k = 0; k < 3; k++) begin
            step(); id_valid = 1; id_rn = 1; id_wb_en = 1; id_dest = 4;
            if (k == 2) begin wb_wb_en = 1; wb_dest = 1; end
            #1;
            checks++;
            if (hazard !== 1'b1 || issue !== 1'b0) begin
                fails++;
                $display("FAIL raw_stall[%0d]: hazard=%b issue=%b required 1 0", k, hazard, issue);
            end
        end
        step(); id_valid = 1; id_rn = 1; id_wb_en = 1; id_dest = 4; #1;
        checks++;
        if (hazard !== 1'b0 || issue !== 1'b1) begin
            fails++;
            $display("FAIL raw_release: hazard=%b issue=%b required 0 1", hazard, issue);
        end
        step(); wb_wb_en = 1; wb_dest = 4;
        $display("test_raw done");
    endtask

    task automatic test_store();
        step(); id_valid = 1; id_wb_en = 1; id_dest = 5; #1;
        step(); id_valid = 1; id_two_src = 1; id_src2 = 5; #1;
        checks++;
        if (hazard !== 1'b1) begin fails++; $display("FAIL store_src2: hazard=%b required 1", hazard); end
        step(); id_valid = 1; id_two_src = 0; id_src2 = 5; #1;
        checks++;
        if (hazard !== 1'b0 || issue !== 1'b1) begin
            fails++;
            $display("FAIL store_one_src: hazard=%b issue=%b required 0 1", hazard, issue);
        end
        step(); wb_wb_en = 1; wb_dest = 5;
        $display("test_store done");
    endtask

    task automatic test_flags();
        step(); id_valid = 1; id_s = 1; #1;
        checks++;
        if (issue !== 1'b1) begin fails++; $display("FAIL flags_cmp_issue: issue=%b required 1", issue); end
        step(); id_valid = 1; id_cond_use = 1; #1;
        checks++;
        if (hazard !== 1'b1) begin fails++; $display("FAIL flags_beq_stall: hazard=%b required 1", hazard); end
        step(); id_valid = 1; id_cond_use = 0; #1;
        checks++;
        if (hazard !== 1'b0) begin fails++; $display("FAIL flags_al: hazard=%b required 0", hazard); end
        step(); id_valid = 1; id_cond_use = 1; sr_commit = 1; #1;
        checks++;
        if (hazard !== 1'b1) begin fails++; $display("FAIL flags_commit_cycle: hazard=%b required 1", hazard); end
        step(); id_valid = 1; id_cond_use = 1; #1;
        checks++;
        if (hazard !== 1'b0 || issue !== 1'b1) begin
            fails++;
            $display("FAIL flags_release: hazard=%b issue=%b required 0 1", hazard, issue);
        end
        $display("test_flags done");
    endtask

    task automatic test_flush();
        step(); id_valid = 1; id_wb_en = 1; id_dest = 6; flush = 1; #1;
        checks++;
        if (issue !== 1'b0) begin fails++; $display("FAIL flush_issue: issue=%b required 0", issue); end
        step(); id_valid = 1; id_rn = 6; #1;
        checks++;
        if (hazard !== 1'b0) begin fails++; $display("FAIL flush_no_count: hazard=%b required 0", hazard); end
        step(); id_valid = 1; id_wb_en = 1; id_dest = 2; #1;
        step(); id_valid = 1; id_wb_en = 1; id_dest = 2; wb_wb_en = 1; wb_dest = 2; #1;
        checks++;
        if (issue !== 1'b1) begin fails++; $display("FAIL simul_issue: issue=%b required 1", issue); end
        step(); id_valid = 1; id_rn = 2; #1;
        checks++;
        if (hazard !== 1'b1) begin fails++; $display("FAIL simul_cancel: hazard=%b required 1", hazard); end
        step(); wb_wb_en = 1; wb_dest = 2;
        step(); id_valid = 1; id_rn = 2; #1;
        checks++;
        if (hazard !== 1'b0 || sb_err !== 1'b0) begin
            fails++;
            $display("FAIL simul_drain: hazard=%b sb_err=%b required 0 0", hazard, sb_err);
        end
        $display("test_flush done");
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 3; k++) begin
            step(); id_valid = 1; id_wb_en = 1; id_dest = 7; #1;
            checks++;
            if (issue !== 1'b1) begin fails++; $display("FAIL sat_issue[%0d]: issue=%b required 1", k, issue); end
        end
        step(); id_valid = 1; id_wb_en = 1; id_dest = 7; #1;
        checks++;
        if (hazard !== 1'b1 || issue !== 1'b0) begin
            fails++;
            $display("FAIL sat_block: hazard=%b issue=%b required 1 0", hazard, issue);
        end
        for (int k = 0; k < 3; k++) begin step(); wb_wb_en = 1; wb_dest = 7; end
        step(); id_valid = 1; id_wb_en = 1; id_dest = 7; id_rn = 7; #1;
        checks++;
        if (hazard !== 1'b0 || sb_err !== 1'b0) begin
            fails++;
            $display("FAIL sat_drained: hazard=%b sb_err=%b required 0 0", hazard, sb_err);
        end
        step(); wb_wb_en = 1; wb_dest = 7;
        $display("test_saturation done");
    endtask

    task automatic test_error();
        step(); wb_wb_en = 1; wb_dest = 9; #1;
        checks++;
        if (sb_err !== 1'b0) begin fails++; $display("FAIL err_same_cycle: sb_err=%b required 0", sb_err); end
        for (int k = 0; k < 3; k++) begin
            step(); id_valid = 1; id_rn = 4'(k + 10); #1;
            checks++;
            if (sb_err !== 1'b1) begin fails++; $display("FAIL err_sticky[%0d]: sb_err=%b required 1", k, sb_err); end
        end
        step(); rst = 1;
        step(); rst = 0; #1;
        checks++;
        if (sb_err !== 1'b0) begin fails++; $display("FAIL err_cleared: sb_err=%b required 0", sb_err); end
        $display("test_error done");
    endtask

    task automatic test_random();
        int r;
        for (int n = 0; n < 600; n++) begin
            step();
            rst         = ($urandom_range(0, 99) == 0);
            id_valid    = ($urandom_range(0, 3) != 0);
            id_rn       = 4'($urandom_range(0, 3));
            id_src2     = 4'($urandom_range(0, 3));
            id_two_src  = 1'($urandom);
            id_wb_en    = ($urandom_range(0, 3) != 0);
            id_dest     = 4'($urandom_range(0, 3));
            id_s        = ($urandom_range(0, 3) == 0);
            id_cond_use = ($urandom_range(0, 3) == 0);
            flush       = ($urandom_range(0, 7) == 0);
            r           = $urandom_range(0, 3);
            wb_dest     = 4'(r);
            wb_wb_en    = (m_cnt[r] > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 63) == 0);
            sr_commit   = (m_sflag > 0) ? 1'($urandom) : ($urandom_range(0, 63) == 0);
            #1;
            checks++;
            if (hazard !== exp_hazard() || issue !== exp_issue() || sb_err !== m_err) begin
                fails++;
                $display("FAIL random[%0d]: hazard=%b issue=%b sb_err=%b required %b %b %b",
                         n, hazard, issue, sb_err, exp_hazard(), exp_issue(), m_err);
            end
        end
        rst = 0;
        $display("test_random done");
    endtask

`ifdef HAZARD_SCOREBOARD_STATS_EN
    task automatic test_stats();
        step(); #1;
        checks++;
        if (stall_cycles !== 32'(m_stall) || issued_cnt !== 32'(m_issued)) begin
            fails++;
            $display("FAIL stats: stall=%0d issued=%0d required %0d %0d", stall_cycles, issued_cnt, m_stall, m_issued);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_raw();
        test_store();
        test_flags();
        test_flush();
        test_saturation();
        test_error();
        test_random();
`ifdef HAZARD_SCOREBOARD_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
